stage_m: RTL and testbench
==========================

// Module: stage_m
// PURPOSE
//  Memory stage of the 5-stage MIPS pipeline; receiving end of the execute-stage outputs.
//  Holds the E/M pipeline register, the word-organised data memory with byte/half stores, and load extension.
//  Hands A3/WD to the M/W register and drives the M-stage forwarding value.
// PARAMETERS
//  DM_AW  10  word-address width; memory holds 2**DM_AW 32-bit words (4 KiB at default)
// PORTS
//  clk        in   1   pipeline clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears register and memory
//  ClearM     in   1   synchronous bubble insert into the E/M register
//  InstrE     in   32  instruction leaving E
//  PCE        in   32  PC of InstrE
//  ALUOutEM   in   32  ALU result from E (memory byte address for loads/stores)
//  RD2EM      in   32  forwarded rt value from E (store data)
//  A3EM       in   5   destination register from E (0 = no write)
//  WDEM       in   32  write-back value from E
//  InstrMW    out  32  registered instruction, passed to W
//  PCMW       out  32  registered PC, passed to W
//  A3MW       out  5   registered destination register
//  WDMW       out  32  load result if InstrM is a load, else registered WDEM
//  ForwardM   out  32  registered WDEM (never the load data; hazard unit stalls load-use)
// BEHAVIOUR
//  E/M register (InstrM, PCM, ALUOutM, RD2M, A3M, WDM):
//   - reset=1: all cleared to 0 immediately, independent of clk; every output reads 0.
//   - rising edge, ClearM=1: InstrM=0 (nop), A3M=0, WDM=0, PCM=PCE; other fields don't-care.
//   - rising edge, otherwise: capture E inputs. Latency E->M = 1 cycle.
//   - reset dominates ClearM; ClearM dominates capture.
//  Decode on InstrM[31:26]: sw 0x2b, sh 0x29, sb 0x28, lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
//   Every other opcode performs no memory access.
//  Address: word index = ALUOutM[DM_AW+1:2]; higher bits ignored (wraps modulo depth).
//  Stores: write at the rising edge that ends InstrM's M cycle.
//   - sw: full word; ALUOutM[1:0] ignored.
//   - sh: lane ALUOutM[1] (0 = bits 15:0, 1 = bits 31:16) <= RD2M[15:0].
//   - sb: lane ALUOutM[1:0] (bits 8*k+7:8*k) <= RD2M[7:0].
//   - untouched lanes keep their value.
//   - no write during reset, or if a bubble occupies M.
//  Loads: combinational read of the addressed word in the same cycle.
//   - lw: whole word; ALUOutM[1:0] ignored.
//   - lh/lhu: halfword selected by ALUOutM[1], sign-/zero-extended.
//   - lb/lbu: byte selected by ALUOutM[1:0], sign-/zero-extended.
//  WDMW = extended load data for a load, else WDM.
//  A3MW = A3M, InstrMW = InstrM, PCMW = PCM, ForwardM = WDM.
//  Store followed by load to the same word in the next cycle: the load returns the new data.
//  Memory reset: all words 0 while reset=1.
//  reset asserted mid-store: the write is lost; the memory still ends all-zero.
// CONFIGURATION
//  DM_WRITE_LOG_EN defined: on every performed store, at the write edge, print
//   $display("%d@%h: *%h <= %h", $time, PCM, {ALUOutM[31:2],2'b00}, merged_word).
//   merged_word is the full 32-bit word after the lane merge.
//  Not defined: no display code is compiled; functional behaviour is identical.
// TESTING
//  Reset: assert reset mid-cycle -> all outputs 0 at once; lw from 0x0 after release -> WDMW=0.
//  sw then lw: RD2EM=0x12345678, addr 0x10 (sw), next lw 0x10 -> WDMW=0x12345678.
//   With DM_WRITE_LOG_EN, exactly one log line shows *00000010 <= 12345678.
//  sb/lb/lbu: word 0x20=0; sb 0x80 @0x23 -> word 0x80000000.
//   lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lw 0x21 -> 0x80000000.
//  sh/lh/lhu: sh 0xBEEF @0x42 onto 0x11112222 -> word 0xBEEF2222.
//   lh 0x42 -> 0xFFFFBEEF; lhu 0x40 -> 0x00002222.
//  ClearM on a sw: memory unchanged, A3MW=0, InstrMW=0; next non-cleared addu passes WDEM to WDMW/ForwardM.
//  Wrap: DM_AW=10, sw 0xAA @0x1004 -> lw 0x0004 returns 0xAA.
//   reset during a sw edge -> lw of that address returns 0.

Source files
------------

// File: rtl/stage_m.sv
// rtl/stage_m.sv - MIPS memory stage: E/M register, byte-lane data memory, load extension
//
// Holds the E/M pipeline register, a word-organised data memory supporting
// sw/sh/sb stores and lw/lh/lhu/lb/lbu loads, and produces the values handed
// to the M/W register plus the M-stage forwarding value.
//
// Parameters:
//   DM_AW     word-address width; memory holds 2**DM_AW 32-bit words
//
// Ports:
//   clk       pipeline clock, all state on rising edge
//   reset     asynchronous active-high; clears E/M register and memory
//   ClearM    synchronous bubble insert into the E/M register
//   InstrE    instruction leaving E
//   PCE       PC of InstrE
//   ALUOutEM  ALU result from E (byte address for loads/stores)
//   RD2EM     forwarded rt value from E (store data)
//   A3EM      destination register from E
//   WDEM      write-back value from E
//   InstrMW   registered instruction to W
//   PCMW      registered PC to W
//   A3MW      registered destination register to W
//   WDMW      extended load data for loads, else registered WDEM
//   ForwardM  registered WDEM
//
// Optional build macro:
//   DM_WRITE_LOG_EN  print one line per performed store at the write edge
module stage_m #(
   parameter int DM_AW = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ClearM,
   input  logic [31:0] InstrE,
   input  logic [31:0] PCE,
   input  logic [31:0] ALUOutEM,
   input  logic [31:0] RD2EM,
   input  logic [4:0]  A3EM,
   input  logic [31:0] WDEM,
   output logic [31:0] InstrMW,
   output logic [31:0] PCMW,
   output logic [4:0]  A3MW,
   output logic [31:0] WDMW,
   output logic [31:0] ForwardM
);

   localparam int DEPTH = 1 << DM_AW;

   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LBU = 6'h24;

   logic [31:0] instr_m, pc_m, alu_m, rd2_m, wd_m;
   logic [4:0]  a3_m;

   logic [31:0] mem [DEPTH];

   logic [5:0]       op;
   logic [DM_AW-1:0] widx;
   logic [31:0]      cur_word;
   logic [31:0]      merged_word;
   logic             is_store;
   logic             is_load;
   logic [31:0]      load_data;
   logic [31:0]      byte_shift;
   logic [15:0]      half_sel;

   // E/M pipeline register. A bubble keeps the PC so W still sees a sane PC;
   // address and store data are don't-care because opcode 0 never touches memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_m <= '0;
         pc_m    <= '0;
         alu_m   <= '0;
         rd2_m   <= '0;
         a3_m    <= '0;
         wd_m    <= '0;
      end else if (ClearM) begin
         instr_m <= '0;
         pc_m    <= PCE;
         alu_m   <= ALUOutEM;
         rd2_m   <= RD2EM;
         a3_m    <= '0;
         wd_m    <= '0;
      end else begin
         instr_m <= InstrE;
         pc_m    <= PCE;
         alu_m   <= ALUOutEM;
         rd2_m   <= RD2EM;
         a3_m    <= A3EM;
         wd_m    <= WDEM;
      end
   end

   assign op       = instr_m[31:26];
   assign widx     = alu_m[DM_AW+1:2];   // upper address bits ignored: wraps modulo depth
   assign cur_word = mem[widx];
   assign is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   assign is_load  = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                     (op == OP_LB) || (op == OP_LBU);

   // Lane merge: only the addressed lanes take store data.
   always_comb begin
      merged_word = cur_word;
      case (op)
         OP_SW: merged_word = rd2_m;
         OP_SH: begin
            if (alu_m[1]) merged_word[31:16] = rd2_m[15:0];
            else          merged_word[15:0]  = rd2_m[15:0];
         end
         OP_SB: begin
            case (alu_m[1:0])
               2'd0:    merged_word[7:0]   = rd2_m[7:0];
               2'd1:    merged_word[15:8]  = rd2_m[7:0];
               2'd2:    merged_word[23:16] = rd2_m[7:0];
               default: merged_word[31:24] = rd2_m[7:0];
            endcase
         end
         default: merged_word = cur_word;
      endcase
   end

   // Whole memory clears asynchronously, so a store coinciding with reset is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (is_store) begin
         mem[widx] <= merged_word;
      end
   end

`ifdef DM_WRITE_LOG_EN
   always @(posedge clk) begin
      if (!reset && is_store)
         $display("%d@%h: *%h <= %h", $time, pc_m, {alu_m[31:2], 2'b00}, merged_word);
   end
`endif

   assign byte_shift = cur_word >> {alu_m[1:0], 3'b000};
   assign half_sel   = alu_m[1] ? cur_word[31:16] : cur_word[15:0];

   always_comb begin
      load_data = cur_word;
      case (op)
         OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data = {16'h0000, half_sel};
         OP_LB:   load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
         OP_LBU:  load_data = {24'h000000, byte_shift[7:0]};
         default: load_data = cur_word;
      endcase
   end

   assign InstrMW  = instr_m;
   assign PCMW     = pc_m;
   assign A3MW     = a3_m;
   assign WDMW     = is_load ? load_data : wd_m;
   assign ForwardM = wd_m;

endmodule

// File: tb/tb_stage_m.sv
// tb/tb_stage_m.sv - self-checking bench for stage_m against a byte-array memory model
module tb_stage_m;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ClearM = 1'b0;
   logic [31:0] InstrE = '0, PCE = '0, ALUOutEM = '0, RD2EM = '0, WDEM = '0;
   logic [4:0]  A3EM = '0;
   logic [31:0] InstrMW, PCMW, WDMW, ForwardM;
   logic [4:0]  A3MW;

   int checks = 0;
   int errors = 0;

   // Reference model: byte-addressed little-endian memory of 4 KiB.
   logic [7:0] mb [4096];
   bit          pend_v;
   logic [5:0]  pend_op;
   logic [31:0] pend_addr, pend_data;

   stage_m #(.DM_AW(10)) dut (
      .clk(clk), .reset(reset), .ClearM(ClearM),
      .InstrE(InstrE), .PCE(PCE), .ALUOutEM(ALUOutEM), .RD2EM(RD2EM),
      .A3EM(A3EM), .WDEM(WDEM),
      .InstrMW(InstrMW), .PCMW(PCMW), .A3MW(A3MW), .WDMW(WDMW), .ForwardM(ForwardM)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int baddr(input logic [31:0] a, input int k);
      return ((int'(a[11:2])) * 4) + k;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      int          off;
      w = {mb[baddr(a,3)], mb[baddr(a,2)], mb[baddr(a,1)], mb[baddr(a,0)]};
      off = int'(a[1:0]);
      b = mb[baddr(a, off)];
      off = a[1] ? 2 : 0;
      h = {mb[baddr(a, off+1)], mb[baddr(a, off)]};
      case (op)
         6'h23: return w;
         6'h21: return {{16{h[15]}}, h};
         6'h25: return {16'h0, h};
         6'h20: return {{24{b[7]}}, b};
         default: return {24'h0, b};
      endcase
   endfunction

   task automatic model_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      int off;
      if (op == 6'h2b) begin
         for (int k = 0; k < 4; k++) mb[baddr(a,k)] = d[8*k +: 8];
      end else if (op == 6'h29) begin
         off = a[1] ? 2 : 0;
         mb[baddr(a,off)]   = d[7:0];
         mb[baddr(a,off+1)] = d[15:8];
      end else begin
         off = int'(a[1:0]);
         mb[baddr(a,off)] = d[7:0];
      end
   endtask

   function automatic bit op_is_load(input logic [5:0] op);
      return op == 6'h23 || op == 6'h21 || op == 6'h25 || op == 6'h20 || op == 6'h24;
   endfunction

   function automatic bit op_is_store(input logic [5:0] op);
      return op == 6'h2b || op == 6'h29 || op == 6'h28;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
      pend_v = 0;
   endtask

   // Present one instruction at E, cross the edge, then check the M-stage outputs.
   task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd2,
                        input logic [4:0] a3, input logic [31:0] wd, input bit clr);
      logic [31:0] r, instr, pc, exp_instr, exp_wd;
      logic [4:0]  exp_a3;
      r = $urandom();
      instr = {op, r[25:0]};
      pc = $urandom() & 32'hFFFF_FFFC;
      InstrE = instr; PCE = pc; ALUOutEM = addr; RD2EM = rd2; A3EM = a3; WDEM = wd; ClearM = clr;
      @(posedge clk);
      if (pend_v) model_store(pend_op, pend_addr, pend_data);
      pend_v = 0;
      #1;
      exp_instr = clr ? 32'h0 : instr;
      exp_a3    = clr ? 5'd0 : a3;
      exp_wd    = clr ? 32'h0 : wd;
      check("InstrMW", InstrMW, exp_instr);
      check("PCMW", PCMW, pc);
      check("A3MW", {27'd0, A3MW}, {27'd0, exp_a3});
      check("ForwardM", ForwardM, exp_wd);
      if (!clr && op_is_load(op)) check("WDMW_load", WDMW, model_load(op, addr));
      else                        check("WDMW", WDMW, exp_wd);
      if (!clr && op_is_store(op)) begin
         pend_v = 1; pend_op = op; pend_addr = addr; pend_data = rd2;
      end
      ClearM = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_instr"}, InstrMW, 32'h0);
      check({tag, "_pc"}, PCMW, 32'h0);
      check({tag, "_a3"}, {27'd0, A3MW}, 32'h0);
      check({tag, "_wd"}, WDMW, 32'h0);
      check({tag, "_fwd"}, ForwardM, 32'h0);
   endtask

   logic [5:0] ops [9] = '{6'h2b, 6'h29, 6'h28, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h00};

   initial begin
      model_reset();
      reset = 1;
      repeat (2) @(posedge clk);
      #2;
      check_all_zero("rst_hold");
      reset = 0;

      // Load the pipeline with something, then reset mid-cycle.
      issue(6'h00, 32'h4, 32'h1, 5'd7, 32'hDEAD_BEEF, 0);
      #2 reset = 1;
      #1 check_all_zero("rst_async");
      model_reset();
      @(negedge clk);
      reset = 0;
      issue(6'h23, 32'h0, 32'h0, 5'd2, 32'h0, 0);
      check("lw0_after_reset", WDMW, 32'h0);

      issue(6'h2b, 32'h10, 32'h1234_5678, 5'd0, 32'h0, 0);
      issue(6'h23, 32'h10, 32'h0, 5'd3, 32'h0, 0);
      check("sw_lw", WDMW, 32'h1234_5678);

      issue(6'h2b, 32'h20, 32'h0, 5'd0, 32'h0, 0);
      issue(6'h28, 32'h23, 32'h80, 5'd0, 32'h0, 0);
      issue(6'h20, 32'h23, 32'h0, 5'd4, 32'h0, 0);
      check("lb", WDMW, 32'hFFFF_FF80);
      issue(6'h24, 32'h23, 32'h0, 5'd4, 32'h0, 0);
      check("lbu", WDMW, 32'h0000_0080);
      issue(6'h23, 32'h21, 32'h0, 5'd4, 32'h0, 0);
      check("sb_word", WDMW, 32'h8000_0000);

      issue(6'h2b, 32'h40, 32'h1111_2222, 5'd0, 32'h0, 0);
      issue(6'h29, 32'h42, 32'h0000_BEEF, 5'd0, 32'h0, 0);
      issue(6'h23, 32'h40, 32'h0, 5'd5, 32'h0, 0);
      check("sh_word", WDMW, 32'hBEEF_2222);
      issue(6'h21, 32'h42, 32'h0, 5'd5, 32'h0, 0);
      check("lh", WDMW, 32'hFFFF_BEEF);
      issue(6'h25, 32'h40, 32'h0, 5'd5, 32'h0, 0);
      check("lhu", WDMW, 32'h0000_2222);

      issue(6'h2b, 32'h50, 32'hCAFE_F00D, 5'd9, 32'h55, 1);
      issue(6'h23, 32'h50, 32'h0, 5'd6, 32'h0, 0);
      check("clear_sw_mem", WDMW, 32'h0);
      issue(6'h00, 32'h0, 32'h0, 5'd8, 32'hA5A5_0001, 0);
      check("addu_fwd", ForwardM, 32'hA5A5_0001);

      issue(6'h2b, 32'h1004, 32'hAA, 5'd0, 32'h0, 0);
      issue(6'h23, 32'h0004, 32'h0, 5'd1, 32'h0, 0);
      check("wrap", WDMW, 32'hAA);

      // Reset held across the edge that would perform a store.
      issue(6'h2b, 32'h8, 32'h77, 5'd0, 32'h0, 0);
      #2 reset = 1;
      @(posedge clk);
      #1 check_all_zero("rst_store");
      model_reset();
      @(negedge clk);
      reset = 0;
      issue(6'h23, 32'h8, 32'h0, 5'd1, 32'h0, 0);
      check("rst_store_lost", WDMW, 32'h0);
      issue(6'h23, 32'h10, 32'h0, 5'd1, 32'h0, 0);
      check("rst_mem_clear", WDMW, 32'h0);

      // Random traffic over a small address window to force overlaps.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a, d, w;
         logic [5:0]  op;
         bit          clr;
         op  = ops[$urandom_range(0, 8)];
         a   = $urandom_range(0, 63);
         if ($urandom_range(0, 7) == 0) a = a | ($urandom() & 32'hFFFF_F000);
         d   = $urandom();
         w   = $urandom();
         clr = ($urandom_range(0, 9) == 0);
         issue(op, a, d, 5'($urandom_range(0, 31)), w, clr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
